// File: rtl/demod_report_sched.sv
// rtl/demod_report_sched.sv - epoch scheduler: measure, settle, classify-stabilise, 6-byte report
module demod_report_sched #(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_CNT     = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        run,
  output logic        meas_start,
  input  logic [2:0]  meas_done,
  input  logic [7:0]  cls_mod_type,
  input  logic [15:0] cls_freq,
  output logic [7:0]  mod_type_commit,
  output logic [15:0] freq_commit,
  output logic        type_change,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 23) ? $clog2(TIMEOUT_CYCLES + 1) : 23;
  localparam int ST_W = ($clog2(SETTLE_CYCLES + 1) > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      STABLE_N = 4'(STABLE_CNT);
  localparam logic [7:0]      SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SETTLE,
    S_DECIDE,
    S_SEND
  } state_t;

  state_t          state;
  logic [2:0]      done_sticky;
  logic [TO_W-1:0] to_cnt;
  logic [ST_W-1:0] st_cnt;
  logic            timeout_flag;
  logic            stable_flag;
  logic [7:0]      cand_type;
  logic [3:0]      streak;
  logic [2:0]      byte_idx;

  logic [2:0]      done_eff;
  logic            type_ok;
  logic [7:0]      cand_next;
  logic [3:0]      streak_next;
  logic            commit_now;
  logic [7:0]      status_byte;
  logic [7:0]      checksum;
  logic [7:0]      next_byte;

  // Stability tracker next values; the current cycle's done pulses count toward all-done
  always_comb begin
    done_eff    = done_sticky | meas_done;
    type_ok     = !timeout_flag && (cls_mod_type >= 8'd1) && (cls_mod_type <= 8'd6);
    cand_next   = cand_type;
    streak_next = streak;
    if (!type_ok) begin
      cand_next   = 8'd0;
      streak_next = 4'd0;
    end else if (cls_mod_type == cand_type) begin
      streak_next = (streak >= STABLE_N) ? STABLE_N : streak + 4'd1;
    end else begin
      cand_next   = cls_mod_type;
      streak_next = 4'd1;
    end
    commit_now = type_ok && (streak_next == STABLE_N);
  end

  // Report byte following the one currently presented on tx_data
  always_comb begin
    status_byte = {6'b0, stable_flag, timeout_flag};
    checksum    = status_byte ^ mod_type_commit ^ freq_commit[15:8] ^ freq_commit[7:0];
    case (byte_idx)
      3'd0:    next_byte = status_byte;
      3'd1:    next_byte = mod_type_commit;
      3'd2:    next_byte = freq_commit[15:8];
      3'd3:    next_byte = freq_commit[7:0];
      default: next_byte = checksum;
    endcase
  end

  // Epoch state machine; the classifier is sampled on the last SETTLE cycle so the
  // committed values and type_change are already visible during DECIDE
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= S_IDLE;
      meas_start      <= 1'b0;
      busy            <= 1'b0;
      done_sticky     <= 3'b0;
      to_cnt          <= '0;
      st_cnt          <= '0;
      timeout_flag    <= 1'b0;
      stable_flag     <= 1'b0;
      cand_type       <= 8'd0;
      streak          <= 4'd0;
      mod_type_commit <= 8'd0;
      freq_commit     <= 16'd0;
      type_change     <= 1'b0;
      tx_data         <= 8'd0;
      tx_valid        <= 1'b0;
      byte_idx        <= 3'd0;
    end else begin
      meas_start  <= 1'b0;
      type_change <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state      <= S_START;
            meas_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_START: begin
          done_sticky  <= 3'b0;
          to_cnt       <= '0;
          timeout_flag <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          done_sticky <= done_eff;
          if (&done_eff) begin
            timeout_flag <= 1'b0;
            st_cnt       <= '0;
            state        <= S_SETTLE;
          end else if (to_cnt == TO_LAST) begin
            timeout_flag <= 1'b1;
            st_cnt       <= '0;
            state        <= S_SETTLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (st_cnt == ST_LAST) begin
            cand_type   <= cand_next;
            streak      <= streak_next;
            stable_flag <= commit_now;
            if (commit_now) begin
              mod_type_commit <= cand_next;
              freq_commit     <= cls_freq;
              type_change     <= (cand_next != mod_type_commit);
            end
            state <= S_DECIDE;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        S_DECIDE: begin
          tx_data  <= SYNC;
          tx_valid <= 1'b1;
          byte_idx <= 3'd0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (byte_idx == 3'd5) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'd0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data  <= next_byte;
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/demod_report_sched.md
# demod_report_sched

Epoch scheduler for the demodulation/classification path. It starts a measurement window on the ASK, FSK and PSK measurement blocks, waits for all three to finish, and samples the classifier's modulation type and frequency. It commits a new type only after the same type is seen in several consecutive epochs. Each epoch ends with a fixed 6-byte report frame sent to the UART transmitter over a valid/ready handshake.

## Interface
Parameters:
- TIMEOUT_CYCLES, 5_000_000: maximum WAIT duration (100 ms at 50 MHz); width ≥ 23 bits.
- SETTLE_CYCLES, 16: wait after all-done before sampling the classifier; ≥ 1.
- STABLE_CNT, 3: consecutive identical valid types required to commit; 1..15.

Ports:
- sys_clk  in  1  system clock, single clock domain.
- sys_rst  in  1  asynchronous, active-high reset.
- run  in  1  level; while high, epochs repeat back to back.
- meas_start  out  1  one-cycle pulse that starts a measurement window.
- meas_done  in  3  per-channel done pulses: bit0 ASK, bit1 FSK, bit2 PSK.
- cls_mod_type  in  8  classifier type code: 1 AM, 2 ASK, 3 FM, 4 FSK, 5 PSK, 6 CW.
- cls_freq  in  16  classifier demodulated frequency, in Hz.
- mod_type_commit  out  8  committed type.
- freq_commit  out  16  committed frequency.
- type_change  out  1  one-cycle pulse when mod_type_commit changes.
- tx_data  out  8  report byte.
- tx_valid  out  1  report byte valid.
- tx_ready  in  1  UART transmitter accepts the byte.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE → START → WAIT → SETTLE → DECIDE → SEND → IDLE.
- IDLE: if run=1, go to START next cycle.
- START: assert meas_start for exactly 1 cycle. Clear the sticky done bits and the timeout counter.
- WAIT:
  - OR meas_done into the sticky done bits each cycle. The effective value includes the current cycle's pulses.
  - When all 3 bits are set, go to SETTLE with timeout_flag=0.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES, go to SETTLE with timeout_flag=1.
  - If all-done and timeout occur in the same cycle, done wins (timeout_flag=0).
- SETTLE: count SETTLE_CYCLES cycles, then go to DECIDE.
- DECIDE (1 cycle) updates the stability tracker (cand_type, 4-bit streak):
  - Timeout, or cls_mod_type outside 1..6: cand_type←0, streak←0. Committed values are untouched.
  - cls_mod_type == cand_type: streak←min(streak+1, STABLE_CNT).
  - Otherwise: cand_type←cls_mod_type, streak←1.
  - When the new streak equals STABLE_CNT: mod_type_commit←cand_type and freq_commit←cls_freq. The frequency therefore refreshes every stable epoch.
  - If the committed type value changes, type_change=1 for the DECIDE cycle only.
- SEND: 6 bytes, in order:
  - 0xA5.
  - status = {6'b0, stable, timeout_flag}, where stable = (streak==STABLE_CNT) after the update.
  - mod_type_commit, freq_commit[15:8], freq_commit[7:0] (post-update values).
  - checksum = XOR of bytes 1..4.
- After the last byte is accepted, return to IDLE.
- run going low mid-epoch: the epoch completes, including the full frame. No truncation.
- meas_done pulses while in IDLE, SETTLE, DECIDE or SEND are ignored.

## Timing
- Reset values: meas_start=0, tx_valid=0, tx_data=0x00, mod_type_commit=0, freq_commit=0, type_change=0, busy=0, cand_type=0, streak=0, state=IDLE.
- Reset asserted mid-frame or mid-epoch: outputs return to reset values immediately (asynchronous). No partial frame resumes.
- Handshake:
  - A byte transfers on a cycle where tx_valid && tx_ready.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - The next byte appears the cycle after a transfer, with tx_valid staying high.
  - tx_valid drops the cycle after byte 5 transfers.
  - tx_valid never depends combinationally on tx_ready.
- Cycle numbering with tx_ready=1 and all done bits arriving in the first WAIT cycle (S = SETTLE_CYCLES):
  - Cycle 0: START.
  - Cycle 1: WAIT.
  - Cycles 2..S+1: SETTLE.
  - Cycle S+2: DECIDE.
  - Cycles S+3..S+8: bytes 0..5.
  - Cycle S+9: IDLE.
  - Cycle S+10: next START if run=1.
- Epoch period under those conditions: S+10 cycles.
- meas_start spacing is never less than S+10 cycles.
- The timeout counter counts WAIT cycles only; its terminal value is TIMEOUT_CYCLES.

## Test plan
- Reset, run=1, done=3'b111 in the first WAIT cycle, cls_mod_type=3, cls_freq=0x07D0, STABLE_CNT=3, tx_ready=1:
  - Frames 1–2: A5 00 00 00 00 00.
  - Frame 3: A5 02 03 07 D0 D6, with type_change pulsed once in the 3rd DECIDE.
  - meas_start period: 26 cycles (S=16).
- Committed type 3, then cls_mod_type=4 for 2 epochs, then 3 again:
  - mod_type_commit stays 3 throughout; no type_change.
  - The 3rd type-4 epoch in a row is required to switch to 4.
- meas_done bit2 never arrives (TIMEOUT_CYCLES=100 in the bench):
  - WAIT lasts 100 cycles.
  - Frame A5 01 <commit> … with the stable bit clear; the streak restarts at 1 the next epoch.
- tx_ready held low 7 cycles on byte 2:
  - tx_data stays equal to mod_type_commit and tx_valid stays 1 throughout.
  - Frame order and checksum are unchanged.
- Reset asserted at byte 3 of a frame:
  - tx_valid drops immediately and commits clear to 0.
  - After release with run=1, the first frame starts with 0xA5.
- run dropped during SETTLE: the current frame is sent in full, then the block stays in IDLE with busy=0 and no further meas_start.
